comb_vc_sw_alloc_wrr: RTL and testbench

- Next-generation combined VC/switch allocator for the ProNoC router.
- Performs switch allocation and output-VC allocation for head flits in one cycle.
- Keeps registered output-VC ownership, per-input-VC assigned-OVC state, round-robin pointers and per-output weighted-round-robin counters.
- Sits between the input-queue control and the crossbar/output-port logic. Generalises the previous allocator to arbitrary V, per-port weights and packet-level OVC hold/release.

---
 rtl/comb_vc_sw_alloc_wrr.sv | 239 +++++++++++++++++++++++
 tb/tb_comb_vc_sw_alloc_wrr.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/comb_vc_sw_alloc_wrr.sv
// comb_vc_sw_alloc_wrr: single-cycle combined switch / output-VC allocator.
// Stage 1 picks one eligible VC per input port (round-robin), stage 2 picks one
// input per output port (weighted round-robin), then a head winner claims an OVC.
// Optional per-output statistics counters: define PRONOC_ALLOC_STATS_EN.
module comb_vc_sw_alloc_wrr #(
  parameter int P            = 5,
  parameter int V            = 4,
  parameter int WEIGHTW      = 4,
  parameter int SELF_LOOP_EN = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [P*V-1:0]       ivc_req_i,
  input  logic [P*V-1:0]       ivc_is_head_i,
  input  logic [P*V-1:0]       ivc_is_tail_i,
  input  logic [P*V*P-1:0]     ivc_dest_port_i,
  input  logic [P*V*V-1:0]     ivc_ovc_mask_i,
  input  logic [P*V-1:0]       ovc_credit_avail_i,
  input  logic [P*WEIGHTW-1:0] iport_weight_i,
  output logic [P*V-1:0]       ivc_sw_grant_o,
  output logic [P*V-1:0]       ivc_ovc_grant_o,
  output logic [P*V*V-1:0]     ivc_granted_ovc_o,
  output logic [P-1:0]         outport_valid_o,
  output logic [P*P-1:0]       outport_src_port_o,
  output logic [P*V-1:0]       outport_ovc_o,
  output logic [P*V-1:0]       ovc_busy_o
`ifdef PRONOC_ALLOC_STATS_EN
  ,
  output logic [P*32-1:0]      stat_grant_cnt_o,
  output logic [P*32-1:0]      stat_conflict_cnt_o
`endif
);
  localparam int VW = (V > 1) ? $clog2(V) : 1;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam logic [WEIGHTW:0] CNT_ONE = 1;

  // Registered allocator state
  logic [P*V-1:0]     ovc_busy_q, ovc_busy_d;
  logic [P*V-1:0]     asg_valid_q, asg_valid_d;
  logic [V-1:0]       asg_ovc_q [P*V];
  logic [V-1:0]       asg_ovc_d [P*V];
  logic [VW-1:0]      in_ptr_q [P];
  logic [VW-1:0]      in_ptr_d [P];
  logic [VW-1:0]      ovc_ptr_q [P];
  logic [VW-1:0]      ovc_ptr_d [P];
  logic [PW-1:0]      out_ptr_q [P];
  logic [PW-1:0]      out_ptr_d [P];
  logic [WEIGHTW-1:0] wcnt_q [P];
  logic [WEIGHTW-1:0] wcnt_d [P];

  // Per input-VC views
  logic [P-1:0]   dest_w [P*V];
  logic [V-1:0]   mask_w [P*V];
  logic [V-1:0]   head_free_w [P*V];
  logic [P*V-1:0] elig_w;

  // Stage results
  logic [P-1:0]   s1_valid;
  logic [VW-1:0]  s1_vc [P];
  logic [P-1:0]   s1_dest [P];
  logic [P-1:0]   cand [P];
  logic [P-1:0]   s2_valid;
  logic [PW-1:0]  s2_src [P];

  genvar gi;
  generate
    for (gi = 0; gi < P*V; gi++) begin : g_ivc
      logic [V-1:0] free_c;
      logic         body_ok_c;
      assign dest_w[gi] = ivc_dest_port_i[gi*P +: P];
      assign mask_w[gi] = ivc_ovc_mask_i[gi*V +: V];
      // Usable OVCs at the destination for a head, credit on the held OVC for a body flit.
      always_comb begin
        free_c    = '0;
        body_ok_c = 1'b0;
        for (int o = 0; o < P; o++) begin
          if (dest_w[gi][o]) begin
            free_c    = free_c | (mask_w[gi] & ~ovc_busy_q[o*V +: V] & ovc_credit_avail_i[o*V +: V]);
            body_ok_c = body_ok_c | (|(asg_ovc_q[gi] & ovc_credit_avail_i[o*V +: V]));
          end
        end
      end
      assign head_free_w[gi] = free_c;
      assign elig_w[gi] = ivc_req_i[gi] && $onehot(dest_w[gi]) &&
                          ((SELF_LOOP_EN != 0) || !dest_w[gi][gi / V]) &&
                          (ivc_is_head_i[gi] ? (|free_c) : (asg_valid_q[gi] && body_ok_c));
    end
  endgenerate

  // Stage 1: per input port, round-robin over eligible VCs starting at in_ptr.
  always_comb begin
    for (int p = 0; p < P; p++) begin
      s1_valid[p] = 1'b0;
      s1_vc[p]    = '0;
      for (int i = 0; i < V; i++) begin
        if (!s1_valid[p] && elig_w[p*V + (int'(in_ptr_q[p]) + i) % V]) begin
          s1_valid[p] = 1'b1;
          s1_vc[p]    = VW'((int'(in_ptr_q[p]) + i) % V);
        end
      end
      s1_dest[p] = s1_valid[p] ? dest_w[p*V + int'(s1_vc[p])] : '0;
    end
  end

  // Stage 2: per output port, first candidate input port starting at out_ptr.
  always_comb begin
    for (int o = 0; o < P; o++) begin
      for (int p = 0; p < P; p++) begin
        cand[o][p] = s1_valid[p] & s1_dest[p][o];
      end
      s2_valid[o] = 1'b0;
      s2_src[o]   = '0;
      for (int i = 0; i < P; i++) begin
        if (!s2_valid[o] && cand[o][(int'(out_ptr_q[o]) + i) % P]) begin
          s2_valid[o] = 1'b1;
          s2_src[o]   = PW'((int'(out_ptr_q[o]) + i) % P);
        end
      end
    end
  end

  // Grant outputs, OVC selection and next-state for ownership, pointers and WRR counters.
  always_comb begin
    int               p_s, v_s, idx_s, c_s;
    logic [WEIGHTW:0] cnt_new, wmax;
    logic [V-1:0]     ovc_oh;
    ovc_busy_d  = ovc_busy_q;
    asg_valid_d = asg_valid_q;
    asg_ovc_d   = asg_ovc_q;
    in_ptr_d    = in_ptr_q;
    ovc_ptr_d   = ovc_ptr_q;
    out_ptr_d   = out_ptr_q;
    wcnt_d      = wcnt_q;
    ivc_sw_grant_o     = '0;
    ivc_ovc_grant_o    = '0;
    ivc_granted_ovc_o  = '0;
    outport_valid_o    = '0;
    outport_src_port_o = '0;
    outport_ovc_o      = '0;
    p_s = 0; v_s = 0; idx_s = 0; c_s = 0;
    cnt_new = '0; wmax = '0; ovc_oh = '0;
    for (int o = 0; o < P; o++) begin
      if (s2_valid[o]) begin
        p_s   = int'(s2_src[o]);
        v_s   = int'(s1_vc[p_s]);
        idx_s = p_s*V + v_s;
        ivc_sw_grant_o[idx_s]        = 1'b1;
        outport_valid_o[o]           = 1'b1;
        outport_src_port_o[o*P+p_s]  = 1'b1;
        in_ptr_d[p_s]                = VW'((v_s + 1) % V);
        if (ivc_is_head_i[idx_s]) begin
          // New packet: claim the first usable OVC at or after ovc_ptr.
          ovc_oh = '0;
          c_s    = 0;
          for (int i = 0; i < V; i++) begin
            if (ovc_oh == '0 && head_free_w[idx_s][(int'(ovc_ptr_q[o]) + i) % V]) begin
              c_s         = (int'(ovc_ptr_q[o]) + i) % V;
              ovc_oh[c_s] = 1'b1;
            end
          end
          ivc_ovc_grant_o[idx_s] = 1'b1;
          ovc_ptr_d[o]           = VW'((c_s + 1) % V);
          if (!ivc_is_tail_i[idx_s]) begin
            ovc_busy_d[o*V + c_s] = 1'b1;
            asg_valid_d[idx_s]    = 1'b1;
            asg_ovc_d[idx_s]      = ovc_oh;
          end else begin
            asg_valid_d[idx_s]    = 1'b0;
          end
        end else begin
          ovc_oh = asg_ovc_q[idx_s];
          if (ivc_is_tail_i[idx_s]) begin
            ovc_busy_d[o*V +: V] = ovc_busy_d[o*V +: V] & ~ovc_oh;
            asg_valid_d[idx_s]   = 1'b0;
          end
        end
        ivc_granted_ovc_o[idx_s*V +: V] = ovc_oh;
        outport_ovc_o[o*V +: V]         = ovc_oh;
        // WRR: the owner keeps the port until its weight is used up; a new winner starts at 1.
        wmax    = (iport_weight_i[p_s*WEIGHTW +: WEIGHTW] == '0) ? CNT_ONE
                  : {1'b0, iport_weight_i[p_s*WEIGHTW +: WEIGHTW]};
        cnt_new = (p_s == int'(out_ptr_q[o])) ? ({1'b0, wcnt_q[o]} + CNT_ONE) : CNT_ONE;
        if (cnt_new >= wmax) begin
          out_ptr_d[o] = PW'((p_s + 1) % P);
          wcnt_d[o]    = '0;
        end else begin
          out_ptr_d[o] = PW'(p_s);
          wcnt_d[o]    = cnt_new[WEIGHTW-1:0];
        end
      end
    end
  end

  // State registers; reset drops all ownership mid-packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovc_busy_q  <= '0;
      asg_valid_q <= '0;
      for (int i = 0; i < P*V; i++) asg_ovc_q[i] <= '0;
      for (int p = 0; p < P; p++) begin
        in_ptr_q[p]  <= '0;
        ovc_ptr_q[p] <= '0;
        out_ptr_q[p] <= '0;
        wcnt_q[p]    <= '0;
      end
    end else begin
      ovc_busy_q  <= ovc_busy_d;
      asg_valid_q <= asg_valid_d;
      asg_ovc_q   <= asg_ovc_d;
      in_ptr_q    <= in_ptr_d;
      ovc_ptr_q   <= ovc_ptr_d;
      out_ptr_q   <= out_ptr_d;
      wcnt_q      <= wcnt_d;
    end
  end

  assign ovc_busy_o = ovc_busy_q;

`ifdef PRONOC_ALLOC_STATS_EN
  generate
    for (gi = 0; gi < P; gi++) begin : g_stats
      logic [31:0] grant_cnt_q, conf_cnt_q;
      // Saturating per-output grant and contention counters.
      always_ff @(posedge clk) begin
        if (reset) begin
          grant_cnt_q <= '0;
          conf_cnt_q  <= '0;
        end else begin
          if (s2_valid[gi] && grant_cnt_q != 32'hFFFF_FFFF) grant_cnt_q <= grant_cnt_q + 32'd1;
          if ($countones(cand[gi]) >= 2 && conf_cnt_q != 32'hFFFF_FFFF) conf_cnt_q <= conf_cnt_q + 32'd1;
        end
      end
      assign stat_grant_cnt_o[gi*32 +: 32]    = grant_cnt_q;
      assign stat_conflict_cnt_o[gi*32 +: 32] = conf_cnt_q;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_comb_vc_sw_alloc_wrr.sv
// Directed bench for comb_vc_sw_alloc_wrr (P=5, V=4, WEIGHTW=4, no self-loop).
module tb_comb_vc_sw_alloc_wrr;
  localparam int P  = 5;
  localparam int V  = 4;
  localparam int WW = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [P*V-1:0]   req, head, tail, credit;
  logic [P*V*P-1:0] dest;
  logic [P*V*V-1:0] mask;
  logic [P*WW-1:0]  weight;
  logic [P*V-1:0]   sw, ovcg, busy, oovc;
  logic [P*V*V-1:0] gov;
  logic [P-1:0]     ovld;
  logic [P*P-1:0]   osrc;
`ifdef PRONOC_ALLOC_STATS_EN
  logic [P*32-1:0]  st_g, st_c;
`endif

  int tests = 0;
  int fails = 0;

  logic [24:0] c_src_exp [6] = '{25'h100000, 25'h100000, 25'h800000, 25'h100000, 25'h100000, 25'h800000};
  logic [19:0] c_ovc_exp [6] = '{20'h10000, 20'h20000, 20'h40000, 20'h80000, 20'h10000, 20'h20000};
  logic [19:0] f_sw_exp  [4] = '{20'h100, 20'h200, 20'h100, 20'h200};

  always #5 clk = ~clk;

  comb_vc_sw_alloc_wrr #(.P(P), .V(V), .WEIGHTW(WW), .SELF_LOOP_EN(0)) dut (
    .clk                (clk),
    .reset              (reset),
    .ivc_req_i          (req),
    .ivc_is_head_i      (head),
    .ivc_is_tail_i      (tail),
    .ivc_dest_port_i    (dest),
    .ivc_ovc_mask_i     (mask),
    .ovc_credit_avail_i (credit),
    .iport_weight_i     (weight),
    .ivc_sw_grant_o     (sw),
    .ivc_ovc_grant_o    (ovcg),
    .ivc_granted_ovc_o  (gov),
    .outport_valid_o    (ovld),
    .outport_src_port_o (osrc),
    .outport_ovc_o      (oovc),
    .ovc_busy_o         (busy)
`ifdef PRONOC_ALLOC_STATS_EN
    ,
    .stat_grant_cnt_o   (st_g),
    .stat_conflict_cnt_o(st_c)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_vc(input int p, input int v, input logic h, input logic t,
                        input logic [P-1:0] d, input logic [V-1:0] m);
    req[p*V+v]             = 1'b1;
    head[p*V+v]            = h;
    tail[p*V+v]            = t;
    dest[(p*V+v)*P +: P]   = d;
    mask[(p*V+v)*V +: V]   = m;
  endtask

  task automatic clr_all();
    req = '0; head = '0; tail = '0; dest = '0; mask = '0;
    credit = '1; weight = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clr_all();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clr_all();

    // A: reset then idle
    do_reset();
    #1;
    chk("A_sw", sw, 0);
    chk("A_ovcg", ovcg, 0);
    chk("A_gov", gov, 0);
    chk("A_valid", ovld, 0);
    chk("A_src", osrc, 0);
    chk("A_oovc", oovc, 0);
    chk("A_busy", busy, 0);

    // B: 3-flit packet, input 1 VC0 -> port 2, OVC1
    set_vc(1, 0, 1'b1, 1'b0, 5'b00100, 4'b0010);
    #1;
    chk("B_head_sw", sw, 20'h10);
    chk("B_head_ovcg", ovcg, 20'h10);
    chk("B_head_gov", gov, 80'h20000);
    chk("B_head_valid", ovld, 5'b00100);
    chk("B_head_src", osrc, 25'h800);
    chk("B_head_oovc", oovc, 20'h200);
    @(negedge clk);
    chk("B_busy_after_head", busy, 20'h200);
    set_vc(1, 0, 1'b0, 1'b0, 5'b00100, 4'b0010);
    #1;
    chk("B_body_sw", sw, 20'h10);
    chk("B_body_ovcg", ovcg, 0);
    chk("B_body_gov", gov, 80'h20000);
    @(negedge clk);
    set_vc(1, 0, 1'b0, 1'b1, 5'b00100, 4'b0010);
    #1;
    chk("B_tail_sw", sw, 20'h10);
    chk("B_tail_oovc", oovc, 20'h200);
    chk("B_busy_during_tail", busy, 20'h200);
    @(negedge clk);
    clr_all();
    #1;
    chk("B_busy_after_tail", busy, 0);
    chk("B_idle_sw", sw, 0);

    // C: WRR, inputs 0 (weight 2) and 3 (weight 1) streaming to port 4
    do_reset();
    weight = 20'h01002;
    set_vc(0, 0, 1'b1, 1'b1, 5'b10000, 4'b1111);
    set_vc(3, 0, 1'b1, 1'b1, 5'b10000, 4'b1111);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("C_src_%0d", i), osrc, c_src_exp[i]);
      chk($sformatf("C_oovc_%0d", i), oovc, c_ovc_exp[i]);
      chk($sformatf("C_sw_%0d", i), sw, (c_src_exp[i] == 25'h100000) ? 20'h1 : 20'h1000);
      @(negedge clk);
    end
    chk("C_busy", busy, 0);

    // D: head blocked behind a busy OVC until the owner's tail has gone
    do_reset();
    set_vc(1, 0, 1'b1, 1'b0, 5'b00100, 4'b0010);
    #1;
    chk("D_owner_head_sw", sw, 20'h10);
    @(negedge clk);
    set_vc(1, 0, 1'b0, 1'b0, 5'b00100, 4'b0010);
    set_vc(0, 0, 1'b1, 1'b0, 5'b00100, 4'b0010);
    #1;
    chk("D_body_sw", sw, 20'h10);
    chk("D_busy", busy, 20'h200);
    @(negedge clk);
    set_vc(1, 0, 1'b0, 1'b1, 5'b00100, 4'b0010);
    #1;
    chk("D_tail_sw", sw, 20'h10);
    @(negedge clk);
    req[4] = 1'b0;
    #1;
    chk("D_new_head_sw", sw, 20'h1);
    chk("D_new_head_ovcg", ovcg, 20'h1);
    chk("D_new_head_gov", gov, 80'h2);
    chk("D_new_head_src", osrc, 25'h400);
    @(negedge clk);
    chk("D_busy_after", busy, 20'h200);

    // E: single-flit packet, self-loop, bad dest, orphan body
    do_reset();
    set_vc(1, 0, 1'b1, 1'b1, 5'b00001, 4'b1111);
    #1;
    chk("E_sw", sw, 20'h10);
    chk("E_ovcg", ovcg, 20'h10);
    chk("E_gov", gov, 80'h10000);
    chk("E_valid", ovld, 5'b00001);
    chk("E_src", osrc, 25'h2);
    chk("E_oovc", oovc, 20'h1);
    @(negedge clk);
    chk("E_busy", busy, 0);
    set_vc(1, 0, 1'b1, 1'b1, 5'b00010, 4'b1111);
    #1;
    chk("E_self_sw", sw, 0);
    chk("E_self_valid", ovld, 0);
    @(negedge clk);
    chk("E_self_sw_2", sw, 0);
    set_vc(1, 0, 1'b1, 1'b1, 5'b00011, 4'b1111);
    #1;
    chk("E_multihot_sw", sw, 0);
    @(negedge clk);
    clr_all();
    set_vc(3, 0, 1'b0, 1'b0, 5'b00001, 4'b1111);
    #1;
    chk("E_orphan_body_sw", sw, 0);
    @(negedge clk);

    // F: stage-1 round-robin on input 2, then credit loss on VC0's OVC
    do_reset();
    set_vc(2, 0, 1'b1, 1'b1, 5'b00001, 4'b0001);
    set_vc(2, 1, 1'b1, 1'b1, 5'b10000, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("F_rr_%0d", i), sw, f_sw_exp[i]);
      @(negedge clk);
    end
    credit = 20'hFFFFE;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("F_nocredit_%0d", i), sw, 20'h200);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
